blk_mem_gen: RTL and testbench

- Single-port synchronous block RAM: 16 words x 8 bits, with a port-enable and a write-enable.
- Used as a generic storage macro inside datapaths and memory-unit exercises.
- One port, clock domain clka; one asynchronous active-low reset.
- Read data is registered: 1-cycle read latency by default.

---
 rtl/blk_mem_gen.sv | 55 +++++
 tb/tb_blk_mem_gen.sv | 125 ++++++++++++
 2 files changed

// File: rtl/blk_mem_gen.sv
// Single-port synchronous RAM with registered, write-first read data.
// Define BLK_MEM_OUT_REG_EN to add a second output register (read latency 2).
module blk_mem_gen #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clka,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  input  logic                  rsta_n
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_dout;

  // Array is cleared by reset, so it is built from flops rather than a RAM macro.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_dout <= '0;
    end else if (ena) begin
      if (wea) begin
        r_mem[addra] <= dina;
        r_dout       <= dina;
      end else begin
        r_dout <= r_mem[addra];
      end
    end
  end

`ifdef BLK_MEM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] r_dout_pipe;

  // Pipeline stage holds with the port, like the RAM output register.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_dout_pipe <= '0;
    end else if (ena) begin
      r_dout_pipe <= r_dout;
    end
  end

  assign douta = r_dout_pipe;
`else
  assign douta = r_dout;
`endif

endmodule

// File: tb/tb_blk_mem_gen.sv
// Directed self-checking bench for blk_mem_gen; follows BLK_MEM_OUT_REG_EN
// to pick the expected read latency.
module tb_blk_mem_gen;

`ifdef BLK_MEM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clka   = 1'b0;
  logic       ena    = 1'b0;
  logic       wea    = 1'b0;
  logic [3:0] addra  = '0;
  logic [7:0] dina   = '0;
  logic [7:0] douta;
  logic       rsta_n = 1'b1;

  int checks   = 0;
  int failures = 0;

  // Expected value produced by each enabled edge, oldest first.
  logic [7:0] exp_q [$];

  blk_mem_gen #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clka   (clka),
    .ena    (ena),
    .wea    (wea),
    .addra  (addra),
    .dina   (dina),
    .douta  (douta),
    .rsta_n (rsta_n)
  );

  always #5 clka = ~clka;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // One access; douta is checked against the value issued LAT edges ago.
  task automatic access(input logic en, input logic we, input logic [3:0] a,
                        input logic [7:0] d, input logic [7:0] exp_new, input string tag);
    ena   = en;
    wea   = we;
    addra = a;
    dina  = d;
    @(posedge clka);
    #1;
    if (en) begin
      exp_q.push_back(exp_new);
      if (exp_q.size() >= LAT) begin
        check_eq(tag, douta, exp_q[exp_q.size() - LAT]);
      end
    end
  endtask

  initial begin
    logic [7:0] exp_v;

    // Power-on reset
    #2 rsta_n = 1'b0;
    #1 check_eq("por_douta", douta, 8'h00);
    @(posedge clka);
    #1 rsta_n = 1'b1;

    // Load 0x5A onto douta, then reset asynchronously mid-cycle
    exp_q.delete();
    access(1'b1, 1'b1, 4'd2, 8'h5A, 8'h5A, "w5a");
    access(1'b1, 1'b0, 4'd2, 8'h00, 8'h5A, "r5a");
    access(1'b1, 1'b0, 4'd2, 8'h00, 8'h5A, "r5a_again");
    check_eq("pre_rst_douta", douta, 8'h5A);
    #3 rsta_n = 1'b0;
    #1 check_eq("async_rst_douta", douta, 8'h00);
    @(posedge clka);
    #1 rsta_n = 1'b1;

    // All words cleared
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      access(1'b1, 1'b0, 4'(i), 8'h00, 8'h00, "rst_word");
    end
    access(1'b1, 1'b0, 4'd15, 8'h00, 8'h00, "rst_word_tail");

    // Write-first burst to 4..8
    for (int i = 0; i < 5; i++) begin
      exp_v = 8'(8'h11 * (i + 1));
      access(1'b1, 1'b1, 4'(4 + i), exp_v, exp_v, "burst");
    end

    // Disabled port ignores a write and holds douta
    access(1'b0, 1'b1, 4'd3, 8'hFF, 8'h00, "dis");
    access(1'b0, 1'b1, 4'd3, 8'hFF, 8'h00, "dis");
    check_eq("dis_hold", douta, exp_q[exp_q.size() - LAT]);

    // Readback sweep
    for (int i = 0; i < 16; i++) begin
      exp_v = (i >= 4 && i <= 8) ? 8'(8'h11 * (i - 3)) : 8'h00;
      access(1'b1, 1'b0, 4'(i), 8'h00, exp_v, "readback");
    end
    access(1'b1, 1'b0, 4'd3, 8'h00, 8'h00, "readback_addr3");

    // Read after write
    access(1'b1, 1'b1, 4'd15, 8'hA5, 8'hA5, "raw_w15");
    access(1'b1, 1'b0, 4'd15, 8'h00, 8'hA5, "raw_r15");
    access(1'b1, 1'b1, 4'd0,  8'h3C, 8'h3C, "raw_w0");
    access(1'b1, 1'b0, 4'd0,  8'h00, 8'h3C, "raw_r0");
    access(1'b1, 1'b0, 4'd15, 8'h00, 8'hA5, "raw_r15_again");
    access(1'b1, 1'b0, 4'd0,  8'h00, 8'h3C, "raw_r0_again");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
